// File: rtl/if_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch front end.
package if_fetch_unit_pkg;

    localparam int unsigned DEFAULT_ADDRESS_LEN = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH  = 2;
    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;

    typedef enum logic {
        StRun,
        StDrop
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer; clear wins over push and pop, push allowed when full if popping.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (AW+1)'(DEPTH));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: empty/valid gating hides stale entries.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch front end: owns the PC, handshakes with instruction memory, buffers
// {pc+4, instr} pairs and applies EXE redirects, dropping an in-flight fetch if needed.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned               ADDRESS_LEN = DEFAULT_ADDRESS_LEN,
    parameter int unsigned               FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter logic [ADDRESS_LEN-1:0]    RESET_PC    = ADDRESS_LEN'(DEFAULT_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_address,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic                   imem_ack,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    output logic                   valid_out,
    output logic [ADDRESS_LEN-1:0] pc_out,
    output logic [ADDRESS_LEN-1:0] instruction_out
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned EW = 2 * ADDRESS_LEN;

    fetch_state_e           state_q;
    logic [ADDRESS_LEN-1:0] pc_q;
    logic [ADDRESS_LEN-1:0] target_q;
    logic [ADDRESS_LEN-1:0] pc_plus4;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [EW-1:0] head_data;
    logic          ack_ok;

    assign pc_plus4 = pc_q + ADDRESS_LEN'(4);
    assign ack_ok   = imem_req & imem_ack;

    // Gated by rst so the request drops immediately on an asynchronous reset.
    assign imem_req  = rst & ((state_q == StDrop) || (fifo_count < CW'(FIFO_DEPTH)));
    assign imem_addr = pc_q;

    assign valid_out       = ~fifo_empty & (state_q == StRun);
    assign pc_out          = valid_out ? head_data[EW-1:ADDRESS_LEN] : '0;
    assign instruction_out = valid_out ? head_data[ADDRESS_LEN-1:0] : '0;

    assign fifo_push = (state_q == StRun) & ack_ok & ~branch_taken;
    assign fifo_pop  = valid_out & ~freeze;

    fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fetch_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .clear     (branch_taken),
        .push_data ({pc_plus4, imem_rdata}),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StRun;
            pc_q     <= RESET_PC;
            target_q <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        if (!imem_req || imem_ack) begin
                            pc_q <= branch_address;
                        end else begin
                            // Request cannot be withdrawn; wait for its ack and discard it.
                            target_q <= branch_address;
                            state_q  <= StDrop;
                        end
                    end else if (ack_ok) begin
                        pc_q <= pc_plus4;
                    end
                end
                StDrop: begin
                    if (imem_ack) begin
                        pc_q    <= branch_taken ? branch_address : target_q;
                        state_q <= StRun;
                    end else if (branch_taken) begin
                        target_q <= branch_address;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a variable-latency instruction memory model.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;

    int checks = 0;
    int errors = 0;
    int mem_lat = 0;
    int wait_cnt = 0;

    always #5 clk = ~clk;

    // Memory returns 0x13000000 + address after mem_lat wait cycles.
    always_comb begin
        imem_ack   = imem_req && (wait_cnt >= mem_lat);
        imem_rdata = imem_ack ? (32'h1300_0000 + imem_addr) : 32'h0;
    end

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    if_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_address  (branch_address),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instruction_out (instruction_out)
    );

    // Leaves time just after the negedge of the first cycle out of reset.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_address = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b want 0", imem_req); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_out); end
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL rst_pc got %h want 0", pc_out); end
        checks++; if (instruction_out !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", instruction_out); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_req got %b want 1", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        mem_lat = 0;
        do_reset();
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL stream_valid0 got %b want 0", valid_out); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            checks++; if (imem_addr !== 32'(4 * k)) begin errors++; $display("FAIL stream_addr%0d got %h want %h", k, imem_addr, 32'(4 * k)); end
            checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL stream_valid%0d got %b want 1", k, valid_out); end
            checks++; if (pc_out !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc%0d got %h want %h", k, pc_out, 32'(4 * k)); end
            checks++; if (instruction_out !== 32'h1300_0000 + 32'(4 * (k - 1))) begin
                errors++; $display("FAIL stream_instr%0d got %h want %h", k, instruction_out, 32'h1300_0000 + 32'(4 * (k - 1)));
            end
        end
    endtask

    task automatic test_freeze();
        mem_lat = 0;
        do_reset();
        @(negedge clk); freeze = 1'b1; #1;
        checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL frz_head_pc got %h want 4", pc_out); end
        for (int k = 2; k <= 4; k++) begin
            @(negedge clk);
            if (k == 4) freeze = 1'b0;
            #1;
            checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL frz_req_c%0d got %b want 0", k, imem_req); end
            checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL frz_addr_c%0d got %h want 8", k, imem_addr); end
            checks++; if (pc_out !== 32'h4) begin errors++; $display("FAIL frz_pc_c%0d got %h want 4", k, pc_out); end
            checks++; if (instruction_out !== 32'h1300_0000) begin errors++; $display("FAIL frz_instr_c%0d got %h want 13000000", k, instruction_out); end
        end
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL frz_rel_req got %b/%h want 1/8", imem_req, imem_addr); end
        checks++; if (pc_out !== 32'h8 || instruction_out !== 32'h1300_0004) begin
            errors++; $display("FAIL frz_rel_head got %h/%h want 8/13000004", pc_out, instruction_out);
        end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'hC || instruction_out !== 32'h1300_0008) begin
            errors++; $display("FAIL frz_b2b_head got %h/%h want c/13000008", pc_out, instruction_out);
        end
    endtask

    task automatic test_branch();
        mem_lat = 0;
        do_reset();
        @(negedge clk); branch_taken = 1'b1; branch_address = 32'h100; #1;
        @(negedge clk); branch_taken = 1'b0; #1;
        checks++; if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++; $display("FAIL br_flush got %b/%h/%h want 0/0/0", valid_out, pc_out, instruction_out);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL br_addr got %b/%h want 1/100", imem_req, imem_addr); end
        @(negedge clk); #1;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h104 || instruction_out !== 32'h1300_0100) begin
            errors++; $display("FAIL br_target got %b/%h/%h want 1/104/13000100", valid_out, pc_out, instruction_out);
        end
    endtask

    task automatic test_drop();
        mem_lat = 3;
        do_reset();
        @(negedge clk); branch_taken = 1'b1; branch_address = 32'h200; #1;
        checks++; if (imem_ack !== 1'b0) begin errors++; $display("FAIL drop_setup_ack got %b want 0", imem_ack); end
        @(negedge clk); branch_address = 32'h300; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL drop_hold1 got %b/%h/%b want 1/0/0", imem_req, imem_addr, valid_out);
        end
        @(negedge clk); branch_taken = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin
            errors++; $display("FAIL drop_hold2 got %b/%h/%b want 1/0/0", imem_req, imem_addr, valid_out);
        end
        for (int k = 4; k <= 7; k++) begin
            @(negedge clk); #1;
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || valid_out !== 1'b0) begin
                errors++; $display("FAIL drop_new_c%0d got %b/%h/%b want 1/300/0", k, imem_req, imem_addr, valid_out);
            end
        end
        @(negedge clk); #1;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h304 || instruction_out !== 32'h1300_0300) begin
            errors++; $display("FAIL drop_target got %b/%h/%h want 1/304/13000300", valid_out, pc_out, instruction_out);
        end
    endtask

    task automatic test_reset_mid_wait();
        mem_lat = 0;
        do_reset();
        @(negedge clk); freeze = 1'b1; mem_lat = 3; #1;
        @(negedge clk); #1;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            errors++; $display("FAIL mid_pre got %b/%h/%b/%h want 1/4/1/4", valid_out, pc_out, imem_req, imem_addr);
        end
        #2; rst = 1'b0; #1;
        checks++; if (imem_req !== 1'b0 || valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
            errors++; $display("FAIL mid_async got %b/%b/%h/%h want 0/0/0/0", imem_req, valid_out, pc_out, instruction_out);
        end
        @(negedge clk); freeze = 1'b0; mem_lat = 0; rst = 1'b1; #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got %b/%h want 1/0", imem_req, imem_addr); end
        @(negedge clk); #1;
        checks++; if (pc_out !== 32'h4 || instruction_out !== 32'h1300_0000) begin
            errors++; $display("FAIL mid_first got %h/%h want 4/13000000", pc_out, instruction_out);
        end
    endtask

    task automatic test_freeze_branch_full();
        mem_lat = 0;
        do_reset();
        freeze = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        checks++; if (imem_req !== 1'b0 || valid_out !== 1'b1) begin errors++; $display("FAIL fb_full got %b/%b want 0/1", imem_req, valid_out); end
        branch_taken = 1'b1; branch_address = 32'h40;
        @(negedge clk); branch_taken = 1'b0; #1;
        checks++; if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            errors++; $display("FAIL fb_redirect got %b/%b/%h want 0/1/40", valid_out, imem_req, imem_addr);
        end
        freeze = 1'b0;
        @(negedge clk); #1;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h44 || instruction_out !== 32'h1300_0040) begin
            errors++; $display("FAIL fb_target got %b/%h/%h want 1/44/13000040", valid_out, pc_out, instruction_out);
        end
    endtask

    task automatic test_wrap();
        mem_lat = 0;
        do_reset();
        @(negedge clk); branch_taken = 1'b1; branch_address = 32'hFFFF_FFFC; #1;
        @(negedge clk); branch_taken = 1'b0; #1;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h want fffffffc", imem_addr); end
        @(negedge clk); #1;
        checks++; if (valid_out !== 1'b1 || pc_out !== 32'h0 || instruction_out !== 32'h12FF_FFFC) begin
            errors++; $display("FAIL wrap_head got %b/%h/%h want 1/0/12fffffc", valid_out, pc_out, instruction_out);
        end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %h want 0", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze();
        test_branch();
        test_drop();
        test_reset_mid_wait();
        test_freeze_branch_full();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that sits directly upstream of the IF stage pipeline register. It owns the program counter, issues word fetches to the instruction memory over a req/ack handshake, and tolerates variable memory latency. Fetched {PC+4, instruction} pairs are buffered in a small FIFO so back-to-back fetch continues while the pipeline is frozen. It applies branch redirects from EXE, including discarding a fetch already in flight.

## Interface
Parameters:
- `ADDRESS_LEN`, 32: address and instruction width.
- `FIFO_DEPTH`, 2: entries in the fetch buffer (≥2, power of two).
- `RESET_PC`, 0: first fetch address after reset.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `freeze`  in  1  hazard stall from ID; head entry is not consumed while high.
- `branch_taken`  in  1  one-cycle redirect pulse from EXE.
- `branch_address`  in  ADDRESS_LEN  redirect target; sampled when `branch_taken`=1.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDRESS_LEN  fetch address; stable while `imem_req`=1 and `imem_ack`=0.
- `imem_ack`  in  1  memory completes the request this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  ADDRESS_LEN  instruction word, valid in the ack cycle.
- `valid_out`  out  1  FIFO head holds a live instruction.
- `pc_out`  out  ADDRESS_LEN  head entry's fetch address + 4; 0 when empty.
- `instruction_out`  out  ADDRESS_LEN  head entry's instruction; 0 (NOP bubble) when empty.

## Operation
- State machine `RUN`/`DROP`; reset to `RUN`.
- `RUN`: `imem_req` = (count < FIFO_DEPTH); `imem_addr` = pc. Once raised, req stays high until ack, because count only grows on ack. On ack: push {pc+4, imem_rdata}, pc ← pc+4.
- Pop when `valid_out` & ~`freeze`. Push and pop in the same cycle are allowed when full. Count is unchanged.
- `branch_taken` in `RUN`:
  - FIFO is cleared, overriding any same-cycle push or pop.
  - If req=0, or req=1 with ack this cycle: pc ← `branch_address`, ack data discarded, stay in `RUN`.
  - If req=1 and no ack: requests cannot be withdrawn. Save the target in `target_q` and go to `DROP`.
- `DROP`:
  - req held high at the old pc, nothing pushed, `valid_out`=0.
  - A further `branch_taken` overwrites `target_q`; the latest target wins.
  - On ack: data discarded, pc ← `target_q` (or `branch_address` if `branch_taken` is high in that same cycle), → `RUN`.
- `branch_taken` has priority over `freeze`.
- `freeze` never blocks requests while FIFO space remains.
- PC arithmetic is modulo 2^ADDRESS_LEN; 0xFFFFFFFC + 4 wraps to 0. No alignment check; the target is used as given.

## Timing
- Reset (asynchronous, immediate): pc=RESET_PC, count=0, state=`RUN`, `target_q`=0, `valid_out`=0, `pc_out`=0, `instruction_out`=0, `imem_req`=0 while `rst`=0.
- First request: `imem_req`=1 in the first cycle after `rst` deasserts.
- Latency: ack in cycle N → entry visible on outputs in cycle N+1 (if FIFO was empty).
- Throughput: zero-wait memory (ack same cycle as req) gives one instruction per cycle.
- Redirect latency (no fetch in flight): `branch_taken` in cycle N → `imem_addr`=target in cycle N+1 → first target instruction on outputs in N+2 at best.
- `valid_out`=0 in cycle N+1 after any `branch_taken`.
- Full FIFO: req low until a pop frees an entry; req rises the cycle after the pop edge.
- Reset mid-`DROP` or mid-wait: the outstanding request is abandoned. Memory must tolerate req dropping on reset.

## Structure
- Add `ADDRESS_LEN`, the `RUN`/`DROP` encoding and `RESET_PC` to the shared `configs.v`.
- Sub-module `fetch_fifo`: synchronous FIFO, parameters width/depth, ports push/pop/clear/full/empty/count, same clock and reset. Clear has priority over push and pop.
- The top level holds the pc register, `target_q` and the FSM.

## Test plan
- Zero-wait memory, freeze=0, RESET_PC=0 → `imem_addr` 0,4,8,… each cycle; `valid_out`=1 from the second cycle; `pc_out` 4,8,12,…
- Zero-wait, `freeze` high 3 cycles while instr@0 is at head → FIFO fills to 2, `imem_addr` holds 8 with req=0, outputs hold instr@0/pc_out=4. After release: instr@4, then instr@8 back-to-back.
- `branch_taken` with `branch_address`=0x100 in an ack cycle → FIFO emptied; `valid_out`=0 next cycle; next `imem_addr`=0x100; later `pc_out`=0x104.
- 3-cycle-latency memory, branch to 0x200 one cycle after req rises → req held at old address until ack; that data never appears; next req at 0x200. A second branch to 0x300 during `DROP` → next req at 0x300.
- `rst` pulled low mid-wait → `imem_req`, `valid_out` and outputs go to 0 without a clock edge. After release, the first `imem_addr`=RESET_PC.
- `freeze`=1 and `branch_taken`=1 in the same cycle with a full FIFO → FIFO cleared and redirect taken despite the freeze.
